// File: rtl/karekok_seri.sv
// rtl/karekok_seri.sv - iterative non-restoring fixed-point square root, one root bit per clock
module karekok_seri #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 8,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          sayi,
  input  logic                      baslat,
  output logic [WIDTH/2+FRAC-1:0]   sonuc,
  output logic [WIDTH/2+FRAC:0]     kalan,
  output logic                      hazir,
  output logic                      bitti,
  output logic                      gecerli,
  output logic                      tasma
);

  localparam int N   = WIDTH/2 + FRAC;
  localparam int RW  = WIDTH + 2*FRAC;
  localparam int RRW = N + 2;
  localparam int CW  = $clog2(N + 1);

  typedef enum logic [1:0] {BOS, HESAP, DUZELT} state_t;

  state_t          state, state_d;
  logic [RW-1:0]   rad;
  logic [N-1:0]    q;
  logic [RRW-1:0]  r;
  logic [CW-1:0]   cnt;
  logic            rej;
  logic            neg_in;
  logic [RRW-1:0]  r_next;
  logic [N:0]      r_fix;

  assign neg_in = (SIGNED != 0) && sayi[WIDTH-1];
  assign hazir  = (state == BOS);

  always_ff @(posedge clk) begin
    if (rst) state <= BOS;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      BOS:     if (baslat) state_d = neg_in ? DUZELT : HESAP;
      HESAP:   if (cnt == '0) state_d = DUZELT;
      DUZELT:  state_d = BOS;
      default: state_d = BOS;
    endcase
  end

  // Arithmetic is mod 2^RRW: the partial remainder always fits, so the
  // bits shifted out of the top can be dropped before the add/subtract.
  always_comb begin
    r_next = '0;
    if (r[RRW-1]) r_next = {r[RRW-3:0], rad[RW-1 -: 2]} + {q, 2'b11};
    else          r_next = {r[RRW-3:0], rad[RW-1 -: 2]} - {q, 2'b01};
    r_fix = r[N:0];
    if (r[RRW-1]) r_fix = r[N:0] + {q, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad     <= '0;
      q       <= '0;
      r       <= '0;
      cnt     <= '0;
      rej     <= 1'b0;
      sonuc   <= '0;
      kalan   <= '0;
      bitti   <= 1'b0;
      gecerli <= 1'b0;
      tasma   <= 1'b0;
    end else begin
      bitti <= 1'b0;
      tasma <= baslat && (state != BOS);
      case (state)
        BOS: begin
          if (baslat) begin
            rad     <= RW'(sayi) << (2*FRAC);
            q       <= '0;
            r       <= '0;
            cnt     <= CW'(N - 1);
            rej     <= neg_in;
            gecerli <= 1'b0;
          end
        end
        HESAP: begin
          rad <= rad << 2;
          r   <= r_next;
          q   <= {q[N-2:0], ~r_next[RRW-1]};
          cnt <= cnt - CW'(1);
        end
        DUZELT: begin
          bitti <= 1'b1;
          if (rej) begin
            sonuc   <= '0;
            kalan   <= '0;
            gecerli <= 1'b0;
          end else begin
            sonuc   <= q;
            kalan   <= r_fix;
            gecerli <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karekok_seri.sv
// tb/tb_karekok_seri.sv - self-checking bench for karekok_seri (unsigned and signed instances)
module tb_karekok_seri;

  localparam int W = 32;
  localparam int F = 8;
  localparam int N = W/2 + F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  sayi0, sayi1;
  logic          baslat0, baslat1;
  logic [N-1:0]  sonuc0, sonuc1;
  logic [N:0]    kalan0, kalan1;
  logic          hazir0, hazir1, bitti0, bitti1, gecerli0, gecerli1, tasma0, tasma1;

  karekok_seri #(.WIDTH(W), .FRAC(F), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .sayi(sayi0), .baslat(baslat0),
    .sonuc(sonuc0), .kalan(kalan0), .hazir(hazir0), .bitti(bitti0),
    .gecerli(gecerli0), .tasma(tasma0));

  karekok_seri #(.WIDTH(W), .FRAC(F), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .sayi(sayi1), .baslat(baslat1),
    .sonuc(sonuc1), .kalan(kalan1), .hazir(hazir1), .bitti(bitti1),
    .gecerli(gecerli1), .tasma(tasma1));

  logic         sel;
  logic [N-1:0] sonuc_m;
  logic [N:0]   kalan_m;
  logic         hazir_m, bitti_m, gecerli_m;
  assign sonuc_m   = sel ? sonuc1   : sonuc0;
  assign kalan_m   = sel ? kalan1   : kalan0;
  assign hazir_m   = sel ? hazir1   : hazir0;
  assign bitti_m   = sel ? bitti1   : bitti0;
  assign gecerli_m = sel ? gecerli1 : gecerli0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor square root of (v * 4^F) by floating-point estimate plus integer fix-up.
  task automatic model(input logic [31:0] v, input bit sgn,
                       output logic [63:0] s, output logic [63:0] rm, output bit ok);
    longint unsigned big, e;
    if (sgn && v[31]) begin
      ok = 0; s = 0; rm = 0;
    end else begin
      ok  = 1;
      big = longint'(v) << (2*F);
      e   = longint'($floor($sqrt(real'(big))));
      while (e*e > big) e--;
      while ((e+1)*(e+1) <= big) e++;
      s  = e;
      rm = big - e*e;
    end
  endtask

  task automatic start(input logic [31:0] v);
    if (sel) begin sayi1 = v; baslat1 = 1'b1; end
    else     begin sayi0 = v; baslat0 = 1'b1; end
    @(negedge clk);
    baslat0 = 1'b0;
    baslat1 = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bitti_m) begin lat = c; break; end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] v);
    logic [63:0] es, er;
    bit ok;
    int lat;
    model(v, sel, es, er, ok);
    chk({tag, ".hazir_in"}, 64'(hazir_m), 64'd1);
    start(v);
    chk({tag, ".busy"}, 64'(hazir_m), 64'd0);
    chk({tag, ".gecerli_clr"}, 64'(gecerli_m), 64'd0);
    wait_done(lat);
    chk({tag, ".latency"}, 64'(lat), ok ? 64'(N + 1) : 64'd1);
    chk({tag, ".sonuc"}, 64'(sonuc_m), es);
    chk({tag, ".kalan"}, 64'(kalan_m), er);
    chk({tag, ".gecerli"}, 64'(gecerli_m), 64'(ok));
    chk({tag, ".hazir"}, 64'(hazir_m), 64'd1);
  endtask

  initial begin
    int lat, cnt;
    logic [31:0] v;
    rst = 1'b1; sel = 1'b0;
    sayi0 = '0; sayi1 = '0; baslat0 = 1'b0; baslat1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.sonuc",   64'(sonuc0),   64'd0);
    chk("rst.kalan",   64'(kalan0),   64'd0);
    chk("rst.hazir",   64'(hazir0),   64'd1);
    chk("rst.bitti",   64'(bitti0),   64'd0);
    chk("rst.gecerli", 64'(gecerli0), 64'd0);
    chk("rst.tasma",   64'(tasma0),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("sq144", 32'd144);
    chk("sq144.const", 64'(sonuc0), 64'd3072);
    run("sq2", 32'd2);
    chk("sq2.const", 64'(kalan0), 64'd28);
    run("max", 32'hFFFF_FFFF);
    chk("max.sonuc_c", 64'(sonuc0), 64'hFF_FFFF);
    chk("max.kalan_c", 64'(kalan0), 64'd33488895);
    run("b2b_zero", 32'd0);

    // Busy request five cycles into a computation
    start(32'd100);
    repeat (5) @(negedge clk);
    sayi0 = 32'd9; baslat0 = 1'b1;
    @(negedge clk);
    baslat0 = 1'b0;
    chk("busy.tasma_hi", 64'(tasma0), 64'd1);
    @(negedge clk);
    chk("busy.tasma_lo", 64'(tasma0), 64'd0);
    wait_done(lat);
    chk("busy.latency", 64'(lat), 64'(N + 1 - 7));
    chk("busy.sonuc", 64'(sonuc0), 64'd2560);
    chk("busy.kalan", 64'(kalan0), 64'd0);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (bitti0) cnt++; end
    chk("busy.no_second", 64'(cnt), 64'd0);

    // Reset in the middle of an operation
    start(32'd5000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.hazir",   64'(hazir0),   64'd1);
    chk("abort.gecerli", 64'(gecerli0), 64'd0);
    chk("abort.sonuc",   64'(sonuc0),   64'd0);
    chk("abort.kalan",   64'(kalan0),   64'd0);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (bitti0) cnt++; end
    chk("abort.no_bitti", 64'(cnt), 64'd0);
    run("after_abort", 32'd144);

    run("one", 32'd1);
    run("three", 32'd3);
    run("pow30", 32'h4000_0000);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      if (i % 4 == 0) v = v >> $urandom_range(31, 8);
      run($sformatf("rnd%0d", i), v);
    end

    sel = 1'b1;
    @(negedge clk);
    run("s_neg", 32'h8000_0000);
    run("s_25", 32'h0000_0019);
    chk("s_25.const", 64'(sonuc1), 64'd1280);
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      v[31] = (i % 3 == 0);
      run($sformatf("srnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
